// File: rtl/io_hsk_sequencer_if.sv
// Pin-level four-phase handshake bundle between the sequencer and the USB-3W peer.
// master: the sequencer side, slave: the peer side.
interface io_hsk_sequencer_if;
    logic in_data_rx_hsk_req;
    logic out_data_rx_hsk_ack;
    logic out_data_tx_hsk_req;
    logic in_data_tx_hsk_ack;

    modport master (
        input  in_data_rx_hsk_req,
        input  in_data_tx_hsk_ack,
        output out_data_rx_hsk_ack,
        output out_data_tx_hsk_req
    );

    modport slave (
        output in_data_rx_hsk_req,
        output in_data_tx_hsk_ack,
        input  out_data_rx_hsk_ack,
        input  out_data_tx_hsk_req
    );
endinterface

// File: rtl/io_hsk_sequencer.sv
// RX/TX four-phase handshake sequencer with strobe synchronisers, TX bursts,
// a wrapping RX word counter and a per-handshake timeout with abort.
module io_hsk_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TO_W        = 16
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    io_hsk_sequencer_if.master   pin,
    output logic                 out_rx_enable,
    output logic                 rx_done,
    output logic                 tx_done,
    output logic                 tx_last,
    input  logic                 rx_continue,
    input  logic                 tx_continue,
    input  logic [CNT_W-1:0]     tx_count,
    input  logic [TO_W-1:0]      timeout_cycles,
    output logic [CNT_W-1:0]     rx_word_cnt,
    output logic                 timeout_err
);

    typedef enum logic [6:0] {
        S_RX_READY    = 7'b0000001,
        S_RX_ACK      = 7'b0000010,
        S_DECODE      = 7'b0000100,
        S_TX_SETUP    = 7'b0001000,
        S_TX_REQ      = 7'b0010000,
        S_TX_WAIT_REL = 7'b0100000,
        S_ABORT       = 7'b1000000
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   req_s;
    logic                   ack_s;

    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             rx_done_q, rx_done_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_last_q, tx_last_d;
    logic             to_err_q, to_err_d;

    logic             counting;
    logic [TO_W:0]    to_next;
    logic             to_hit;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], pin.in_data_rx_hsk_req};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], pin.in_data_tx_hsk_ack};
        end
    end

    assign req_s = req_sync_q[SYNC_STAGES-1];
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // to_next is the number of cycles spent in the state including this one
    assign to_next = {1'b0, to_cnt_q} + {{TO_W{1'b0}}, 1'b1};
    assign to_hit  = (timeout_cycles != '0) &&
                     (to_next == {1'b0, timeout_cycles});

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        to_cnt_d    = to_cnt_q;
        rx_done_d   = 1'b0;
        tx_done_d   = 1'b0;
        tx_last_d   = 1'b0;
        to_err_d    = 1'b0;
        counting    = 1'b0;

        case (state_q)
            S_RX_READY: begin
                if (req_s) state_d = S_RX_ACK;
            end
            S_RX_ACK: begin
                counting = 1'b1;
                if (!req_s) begin
                    state_d    = S_DECODE;
                    rx_done_d  = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (rx_continue) begin
                    state_d = S_RX_READY;
                end else if (tx_continue) begin
                    if (tx_count == '0) begin
                        state_d = S_RX_READY;
                    end else begin
                        state_d     = S_TX_SETUP;
                        remaining_d = tx_count;
                    end
                end
            end
            S_TX_SETUP: begin
                if (tx_continue) state_d = S_TX_REQ;
            end
            S_TX_REQ: begin
                counting = 1'b1;
                if (ack_s) begin
                    state_d     = S_TX_WAIT_REL;
                    tx_done_d   = 1'b1;
                    tx_last_d   = (remaining_q == CNT_W'(1));
                    remaining_d = remaining_q - 1'b1;
                end
            end
            S_TX_WAIT_REL: begin
                counting = 1'b1;
                if (!ack_s) begin
                    state_d = (remaining_q != '0) ? S_TX_SETUP : S_RX_READY;
                end
            end
            S_ABORT: begin
                if (!req_s && !ack_s) state_d = S_RX_READY;
            end
            default: begin
                state_d = S_RX_READY;
            end
        endcase

        // An expired handshake overrides whatever progress was made this cycle
        if (counting && to_hit) begin
            state_d     = S_ABORT;
            to_err_d    = 1'b1;
            remaining_d = '0;
            word_cnt_d  = word_cnt_q;
            rx_done_d   = 1'b0;
            tx_done_d   = 1'b0;
            tx_last_d   = 1'b0;
        end

        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (counting && !(&to_cnt_q)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= S_RX_READY;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            to_cnt_q    <= '0;
            rx_done_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_last_q   <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rx_done_q   <= rx_done_d;
            tx_done_q   <= tx_done_d;
            tx_last_q   <= tx_last_d;
            to_err_q    <= to_err_d;
        end
    end

    assign out_rx_enable           = state_q[0];
    assign pin.out_data_rx_hsk_ack = state_q[1];
    assign pin.out_data_tx_hsk_req = state_q[4];
    assign rx_done                 = rx_done_q;
    assign tx_done                 = tx_done_q;
    assign tx_last                 = tx_last_q;
    assign rx_word_cnt             = word_cnt_q;
    assign timeout_err             = to_err_q;

endmodule

// File: tb/tb_io_hsk_sequencer.sv
// Directed bench for io_hsk_sequencer: reset, RX words and wrap, TX burst,
// DECODE priority, timeouts on both paths and asynchronous reset mid-handshake.
module tb_io_hsk_sequencer;

    localparam int CNT_W = 8;
    localparam int TO_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             rx_enable;
    logic             rx_done;
    logic             tx_done;
    logic             tx_last;
    logic             rx_continue;
    logic             tx_continue;
    logic [CNT_W-1:0] tx_count;
    logic [TO_W-1:0]  timeout_cycles;
    logic [CNT_W-1:0] rx_word_cnt;
    logic             timeout_err;

    logic             auto_ack;

    int n_chk;
    int n_err;
    int n_rx_done;
    int n_tx_done;
    int n_tx_last;
    int n_to_err;
    int last_at;

    io_hsk_sequencer_if hif ();

    io_hsk_sequencer #(
        .SYNC_STAGES(2),
        .CNT_W(CNT_W),
        .TO_W(TO_W)
    ) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .pin(hif),
        .out_rx_enable(rx_enable),
        .rx_done(rx_done),
        .tx_done(tx_done),
        .tx_last(tx_last),
        .rx_continue(rx_continue),
        .tx_continue(tx_continue),
        .tx_count(tx_count),
        .timeout_cycles(timeout_cycles),
        .rx_word_cnt(rx_word_cnt),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peer TX side: instant acknowledge mirrors the request when enabled
    always @(negedge clk) begin
        hif.in_data_tx_hsk_ack = auto_ack ? hif.out_data_tx_hsk_req : 1'b0;
    end

    always @(negedge clk) begin
        if (rx_done) n_rx_done++;
        if (tx_done) n_tx_done++;
        if (tx_last) n_tx_last++;
        if (tx_done && tx_last) last_at = n_tx_done;
        if (timeout_err) n_to_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rx_ack(input logic v, input string tag);
        int n = 0;
        while (hif.out_data_rx_hsk_ack !== v && n < 50) begin
            step(1);
            n++;
        end
        chk(tag, hif.out_data_rx_hsk_ack, v);
    endtask

    task automatic wait_tx_req(input logic v, input string tag);
        int n = 0;
        while (hif.out_data_tx_hsk_req !== v && n < 50) begin
            step(1);
            n++;
        end
        chk(tag, hif.out_data_tx_hsk_req, v);
    endtask

    task automatic wait_rx_enable(input int lim, input string tag);
        int n = 0;
        while (rx_enable !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, rx_enable, 1'b1);
    endtask

    // One RX handshake; ends on the first sample in DECODE
    task automatic rx_word(input string tag);
        hif.in_data_rx_hsk_req = 1'b1;
        wait_rx_ack(1'b1, tag);
        hif.in_data_rx_hsk_req = 1'b0;
        wait_rx_ack(1'b0, tag);
    endtask

    initial begin
        int base;
        int high_cnt;
        n_chk = 0;
        n_err = 0;
        n_rx_done = 0;
        n_tx_done = 0;
        n_tx_last = 0;
        n_to_err = 0;
        last_at = 0;
        rst_n = 1'b0;
        auto_ack = 1'b0;
        rx_continue = 1'b0;
        tx_continue = 1'b0;
        tx_count = '0;
        timeout_cycles = '0;
        hif.in_data_rx_hsk_req = 1'b0;

        // Reset held while peer strobes toggle
        for (int i = 0; i < 4; i++) begin
            hif.in_data_rx_hsk_req = i[0];
            auto_ack = i[1];
            step(1);
        end
        chk("rst_rx_enable", rx_enable, 1'b1);
        chk("rst_rx_ack", hif.out_data_rx_hsk_ack, 1'b0);
        chk("rst_tx_req", hif.out_data_tx_hsk_req, 1'b0);
        chk("rst_pulses", {rx_done, tx_done, tx_last, timeout_err}, 4'b0);
        chk("rst_word_cnt", rx_word_cnt, 8'd0);
        hif.in_data_rx_hsk_req = 1'b0;
        auto_ack = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // Single RX word, latency 3 edges each way
        hif.in_data_rx_hsk_req = 1'b1;
        step(2);
        chk("rx_ack_early", hif.out_data_rx_hsk_ack, 1'b0);
        step(1);
        chk("rx_ack_rise", hif.out_data_rx_hsk_ack, 1'b1);
        chk("rx_enable_off", rx_enable, 1'b0);
        hif.in_data_rx_hsk_req = 1'b0;
        step(2);
        chk("rx_ack_hold", hif.out_data_rx_hsk_ack, 1'b1);
        chk("rx_done_early", rx_done, 1'b0);
        step(1);
        chk("rx_ack_fall", hif.out_data_rx_hsk_ack, 1'b0);
        chk("rx_done_pulse", rx_done, 1'b1);
        chk("rx_cnt_1", rx_word_cnt, 8'd1);
        step(1);
        chk("rx_done_1cyc", rx_done, 1'b0);
        chk("decode_wait", rx_enable, 1'b0);
        rx_continue = 1'b1;
        step(1);
        chk("decode_to_ready", rx_enable, 1'b1);
        chk("rx_done_count", n_rx_done, 1);

        // 255 more words wrap the 8-bit counter
        for (int i = 0; i < 255; i++) begin
            rx_word("rx_wrap_hsk");
            step(1);
            if (i == 126) chk("rx_cnt_128", rx_word_cnt, 8'd128);
        end
        chk("rx_cnt_wrap", rx_word_cnt, 8'd0);
        chk("rx_done_total", n_rx_done, 256);
        rx_continue = 1'b0;

        // Burst of 3 with tx_continue held
        auto_ack = 1'b1;
        rx_word("to_decode_burst");
        base = n_tx_done;
        tx_count = 8'd3;
        tx_continue = 1'b1;
        step(1);
        chk("tx_setup_req_low", hif.out_data_tx_hsk_req, 1'b0);
        chk("tx_setup_rx_en", rx_enable, 1'b0);
        wait_rx_enable(200, "burst_return");
        tx_continue = 1'b0;
        chk("burst_tx_done", n_tx_done - base, 3);
        chk("burst_tx_last", n_tx_last, 1);
        chk("burst_last_pos", last_at - base, 3);
        chk("burst_req_low", hif.out_data_tx_hsk_req, 1'b0);

        // DECODE with both continues: rx wins
        rx_word("to_decode_both");
        base = n_tx_done;
        rx_continue = 1'b1;
        tx_continue = 1'b1;
        tx_count = 8'd2;
        step(1);
        chk("both_rx_enable", rx_enable, 1'b1);
        step(6);
        chk("both_no_req", hif.out_data_tx_hsk_req, 1'b0);
        chk("both_no_tx_done", n_tx_done - base, 0);
        rx_continue = 1'b0;
        tx_continue = 1'b0;

        // DECODE with tx_count 0
        rx_word("to_decode_zero");
        tx_count = 8'd0;
        tx_continue = 1'b1;
        step(1);
        chk("zero_rx_enable", rx_enable, 1'b1);
        step(4);
        chk("zero_no_req", hif.out_data_tx_hsk_req, 1'b0);
        tx_continue = 1'b0;

        // TX timeout of 10 cycles with no ack
        auto_ack = 1'b0;
        timeout_cycles = 16'd10;
        rx_word("to_decode_to");
        tx_count = 8'd1;
        tx_continue = 1'b1;
        wait_tx_req(1'b1, "to_req_rise");
        tx_continue = 1'b0;
        step(9);
        chk("to_req_held", hif.out_data_tx_hsk_req, 1'b1);
        chk("to_no_err_yet", timeout_err, 1'b0);
        step(1);
        chk("to_req_drop", hif.out_data_tx_hsk_req, 1'b0);
        chk("to_err_pulse", timeout_err, 1'b1);
        chk("to_abort_rx_en", rx_enable, 1'b0);
        step(1);
        chk("to_err_1cyc", timeout_err, 1'b0);
        chk("to_recover", rx_enable, 1'b1);
        chk("to_err_count", n_to_err, 1);

        // Timeout disabled: request held 1000 cycles
        timeout_cycles = 16'd0;
        rx_word("to_decode_notimeout");
        tx_count = 8'd1;
        tx_continue = 1'b1;
        wait_tx_req(1'b1, "nto_req_rise");
        tx_continue = 1'b0;
        high_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (hif.out_data_tx_hsk_req === 1'b1) high_cnt++;
        end
        chk("nto_req_1000", high_cnt, 1000);
        chk("nto_no_err", n_to_err, 1);
        auto_ack = 1'b1;
        wait_rx_enable(50, "nto_complete");
        chk("nto_last", tx_last === 1'b0 && n_tx_last == 2, 1'b1);

        // RX stall: peer holds req, timeout 5
        timeout_cycles = 16'd5;
        base = rx_word_cnt;
        hif.in_data_rx_hsk_req = 1'b1;
        wait_rx_ack(1'b1, "stall_ack_rise");
        step(4);
        chk("stall_ack_held", hif.out_data_rx_hsk_ack, 1'b1);
        step(1);
        chk("stall_ack_drop", hif.out_data_rx_hsk_ack, 1'b0);
        chk("stall_err", timeout_err, 1'b1);
        step(10);
        chk("stall_in_abort", rx_enable, 1'b0);
        hif.in_data_rx_hsk_req = 1'b0;
        step(2);
        chk("stall_abort_wait", rx_enable, 1'b0);
        step(1);
        chk("stall_ready", rx_enable, 1'b1);
        chk("stall_cnt_same", rx_word_cnt, base);
        chk("stall_err_count", n_to_err, 2);

        // Asynchronous reset during TX_REQ
        timeout_cycles = 16'd0;
        auto_ack = 1'b0;
        rx_word("to_decode_rst");
        tx_count = 8'd2;
        tx_continue = 1'b1;
        wait_tx_req(1'b1, "arst_req_rise");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_drop", hif.out_data_tx_hsk_req, 1'b0);
        chk("arst_rx_enable", rx_enable, 1'b1);
        chk("arst_word_cnt", rx_word_cnt, 8'd0);
        tx_continue = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("arst_idle", rx_enable, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/io_hsk_sequencer.md
# io_hsk_sequencer

Parametrised handshake sequencer between the USB-3W pin-level data interface and the protocol decoder. It runs four-phase req/ack handshakes on the receive and transmit paths and synchronises both asynchronous peer strobes through a configurable flop chain. It adds multi-word transmit bursts, a wrapping received-word counter, and a per-handshake timeout with abort and recovery. It sits between the I/O pins and the protocol decoder, which it drives through `rx_done`, `tx_done` and `tx_last` pulses.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `in_data_rx_hsk_req` and `in_data_tx_hsk_ack`; legal range 2..4.
- `CNT_W`, default 8: width of the burst length and word counter.
- `TO_W`, default 16: width of the timeout counter.
- `in_clk`  in  1  sole clock, rising edge.
- `in_rst_n`  in  1  reset, asynchronous assertion, active-low.
- `in_data_rx_hsk_req`  in  1  peer RX request; asynchronous.
- `out_data_rx_hsk_ack`  out  1  RX acknowledge to peer.
- `out_data_tx_hsk_req`  out  1  TX request to peer.
- `in_data_tx_hsk_ack`  in  1  peer TX acknowledge; asynchronous.
- `out_rx_enable`  out  1  high while idle and ready to receive.
- `rx_done`  out  1  1-cycle pulse: RX word received.
- `tx_done`  out  1  1-cycle pulse: TX word acknowledged.
- `tx_last`  out  1  high together with `tx_done` on the final word of a burst.
- `rx_continue`  in  1  decoder: return to receive.
- `tx_continue`  in  1  decoder: start a burst, or next TX word ready.
- `tx_count`  in  CNT_W  burst length; sampled when a burst is accepted.
- `timeout_cycles`  in  TO_W  timeout limit; 0 disables the timeout.
- `rx_word_cnt`  out  CNT_W  received-word count; wraps.
- `timeout_err`  out  1  1-cycle pulse on abort.

## Operation
- Synchronised signals `req_s` and `ack_s` are the outputs of the SYNC_STAGES-deep flop chains. Synchroniser flops reset to 0.
- All outputs come from registered, one-hot state and pulse flops. No combinational path from inputs to outputs.
- States and transitions:
  - RX_READY: `out_rx_enable`=1. `req_s`=1 → RX_ACK.
  - RX_ACK: `out_data_rx_hsk_ack`=1. `req_s`=0 → DECODE. On that edge, `rx_done` is set for 1 cycle and `rx_word_cnt`+1 (modulo 2^CNT_W).
  - DECODE: `rx_continue`=1 → RX_READY; `rx_continue` has priority when both are high. Otherwise `tx_continue`=1: if `tx_count`=0 → RX_READY; else load `remaining`=`tx_count` → TX_SETUP.
  - TX_SETUP: all handshake outputs 0. Advances to TX_REQ when `tx_continue`=1 (minimum 1 cycle). The decoder must present valid TX data before asserting `tx_continue`.
  - TX_REQ: `out_data_tx_hsk_req`=1. `ack_s`=1 → TX_WAIT_REL. On that edge: `tx_done` pulses, `remaining`-1, and `tx_last`=(`remaining`==1).
  - TX_WAIT_REL: request low. `ack_s`=0 → TX_SETUP if `remaining`≠0, else RX_READY.
  - ABORT: all handshake outputs 0 and `out_rx_enable`=0. Exits to RX_READY once `req_s`=0 and `ack_s`=0.
- Timeout:
  - The TO_W counter clears on every state change and counts only in RX_ACK, TX_REQ and TX_WAIT_REL.
  - When `timeout_cycles`≠0 and the count equals `timeout_cycles`, the FSM moves to ABORT. On the same edge, `timeout_err` pulses and `remaining` clears.
  - The counter saturates; it never wraps.
  - RX_READY, TX_SETUP and DECODE wait indefinitely.
- Illegal or unreachable state → RX_READY.

## Timing
- Reset values (applied asynchronously, held while `in_rst_n`=0): state RX_READY, `out_rx_enable`=1, all other outputs 0, `rx_word_cnt`=0, `remaining`=0, timeout counter 0.
- Reset mid-burst drops `out_data_tx_hsk_req` or `out_data_rx_hsk_ack` immediately, without waiting for a clock edge.
- Input to state latency: a change on a peer strobe reaches the FSM SYNC_STAGES edges later; the FSM then changes state on the next edge.
- Handshake outputs change on the same edge the state is entered.
- `rx_done` is high during the first cycle of DECODE. `tx_done`/`tx_last` are high during the first cycle of TX_WAIT_REL.
- Decoder inputs are synchronous to `in_clk` and are sampled only in DECODE and TX_SETUP.
- Minimum TX word period: 3 + 2·SYNC_STAGES cycles, assuming the peer responds instantly.

## Test plan
- Reset: hold `in_rst_n`=0, toggle peer inputs → `out_rx_enable`=1, all other outputs 0. Assert reset during TX_REQ → `out_data_tx_hsk_req` falls asynchronously.
- RX word (SYNC_STAGES=2): raise req, then drop it → ack rises 3 cycles after req rises and falls 3 cycles after req falls; one `rx_done` pulse; `rx_word_cnt` 0→1. Repeat 256 times with CNT_W=8 → `rx_word_cnt` wraps to 0.
- TX burst, `tx_count`=3 with `tx_continue` held → 3 req/ack cycles; `tx_done`×3; `tx_last` only on the third; returns to RX_READY.
- DECODE with `rx_continue`=`tx_continue`=1 → RX_READY, no TX request. DECODE with `tx_count`=0 and `tx_continue`=1 → RX_READY.
- Timeout: `timeout_cycles`=10, peer never acks → request drops 10 cycles after TX_REQ entry with one `timeout_err` pulse; after req/ack are low, `out_rx_enable`=1. Repeat with `timeout_cycles`=0 → request stays high indefinitely (checked for 1000 cycles).
- RX stall: `timeout_cycles`=5, peer holds req high → ABORT with `timeout_err`; FSM stays in ABORT until req is released, then RX_READY.
